int_res_readout: RTL and testbench

//  Reader side of the intermediate-result memory map: after inference completes, fetches a vector of
//  NUM_SLEEP_STAGES-style results (or any contiguous vector) from int-res memory and streams it to the host

---
 rtl/int_res_readout.sv | 151 +++++++++++++++
 tb/tb_int_res_readout.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_res_readout.sv
// int_res_readout: streams a contiguous vector of intermediate results from
// int-res memory to the host over valid/ready, one read outstanding at a time,
// and reports the index of the largest (signed) element once the vector is sent.
module int_res_readout #(
  parameter int INT_RES_DEPTH = 57344,
  parameter int ADDR_W        = 16,
  parameter int SW_W          = 15,
  parameter int DW_W          = 30,
  parameter int LEN_W         = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_elem,
  input  logic              width,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              mem_rd_width,
  input  logic [DW_W-1:0]   mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW_W-1:0]   out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  argmax_idx
);

  // Two extra bits so base + 2*64 can never wrap before the depth check.
  localparam int EW       = ADDR_W + 2;
  localparam int MAX_ELEM = 64;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_READ, S_WAIT, S_SEND, S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  base_reg;
  logic [LEN_W-1:0]   num_reg;
  logic               width_reg;
  logic [LEN_W-1:0]   idx_reg;
  logic [DW_W-1:0]    max_reg;
  logic [LEN_W-1:0]   win_reg;
  logic               err_reg;
  logic [DW_W-1:0]    out_data_reg;
  logic               out_last_reg;
  logic [LEN_W-1:0]   argmax_idx_reg;

  logic [EW-1:0]      span;
  logic [EW-1:0]      end_addr;
  logic               range_bad;
  logic [ADDR_W-1:0]  idx_ext;
  logic [ADDR_W-1:0]  rd_addr;
  logic [DW_W-1:0]    rd_sext;
  logic               is_last;
  logic               better;

  // Address arithmetic, range check and element comparison.
  always_comb begin
    span      = width_reg ? (EW'(num_reg) << 1) : EW'(num_reg);
    end_addr  = EW'(base_reg) + span;
    range_bad = (num_reg > LEN_W'(MAX_ELEM)) || (end_addr > EW'(INT_RES_DEPTH));
    idx_ext   = ADDR_W'(idx_reg);
    rd_addr   = base_reg + (width_reg ? (idx_ext << 1) : idx_ext);
    rd_sext   = {{(DW_W-SW_W){mem_rd_data[SW_W-1]}}, mem_rd_data[SW_W-1:0]};
    is_last   = (idx_reg == (num_reg - LEN_W'(1)));
    // Strict greater-than so ties keep the earlier index.
    better    = (idx_reg == '0) || ($signed(out_data_reg) > $signed(max_reg));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_CHECK;
      S_CHECK: state_next = ((num_reg == '0) || range_bad) ? S_DONE : S_READ;
      S_READ:  state_next = S_WAIT;
      S_WAIT:  if (mem_rd_valid) state_next = S_SEND;
      S_SEND:  if (out_ready) state_next = out_last_reg ? S_DONE : S_READ;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Transfer context, captured element and running argmax.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_reg       <= '0;
      num_reg        <= '0;
      width_reg      <= 1'b0;
      idx_reg        <= '0;
      max_reg        <= '0;
      win_reg        <= '0;
      err_reg        <= 1'b0;
      out_data_reg   <= '0;
      out_last_reg   <= 1'b0;
      argmax_idx_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (start) begin
          base_reg  <= base_addr;
          num_reg   <= num_elem;
          width_reg <= width;
          idx_reg   <= '0;
          max_reg   <= '0;
          win_reg   <= '0;
          err_reg   <= 1'b0;
        end
        S_CHECK: err_reg <= (num_reg != '0) && range_bad;
        S_WAIT: if (mem_rd_valid) begin
          out_data_reg <= width_reg ? mem_rd_data : rd_sext;
          out_last_reg <= is_last;
        end
        S_SEND: if (out_ready) begin
          if (better) begin
            max_reg <= out_data_reg;
            win_reg <= idx_reg;
          end
          idx_reg <= idx_reg + LEN_W'(1);
          // Publish the winner as the transfer ends so it is valid alongside done.
          if (out_last_reg) argmax_idx_reg <= better ? idx_reg : win_reg;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the state.
  always_comb begin
    mem_rd_en    = (state_reg == S_READ);
    mem_rd_addr  = (state_reg == S_READ) ? rd_addr : '0;
    mem_rd_width = (state_reg == S_READ) ? width_reg : 1'b0;
    out_valid    = (state_reg == S_SEND);
    out_data     = out_data_reg;
    out_last     = (state_reg == S_SEND) && out_last_reg;
    busy         = (state_reg != S_IDLE);
    done         = (state_reg == S_DONE);
    err          = (state_reg == S_DONE) && err_reg;
    argmax_idx   = argmax_idx_reg;
  end

endmodule

// File: tb/tb_int_res_readout.sv
// Scoreboard bench for int_res_readout: stimulus pushes expected reads, elements
// and done/argmax results; a memory responder and an output monitor check them.
module tb_int_res_readout;

  logic        clk, rst, start, width, mem_rd_en, mem_rd_width, mem_rd_valid;
  logic        out_valid, out_ready, out_last, busy, done, err;
  logic [15:0] base_addr, mem_rd_addr;
  logic [6:0]  num_elem, argmax_idx;
  logic [29:0] mem_rd_data, out_data;

  int_res_readout dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_elem(num_elem),
    .width(width), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_width(mem_rd_width), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err(err), .argmax_idx(argmax_idx)
  );

  typedef struct packed { logic [15:0] a; logic w; } rd_t;
  typedef struct packed { logic [29:0] d; logic l; } el_t;
  typedef struct packed { logic e; logic [6:0] idx; logic chk_lat; } dn_t;

  rd_t exp_rd_q[$];
  el_t exp_el_q[$];
  dn_t exp_dn_q[$];
  logic [29:0] mem [int];

  int nvec = 0, nfail = 0;
  int cyc = 0, hs_cnt = 0, done_cnt = 0, last_hs_cyc = 0;
  int rd_lat = 2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: checks each request, answers after rd_lat cycles.
  initial begin
    rd_t got, want;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_rd_en) begin
        got = '{a: mem_rd_addr, w: mem_rd_width};
        nvec++;
        if (exp_rd_q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_read: got addr=%0d width=%0d, required no read", got.a, got.w);
        end else begin
          want = exp_rd_q.pop_front();
          if (got != want) begin
            nfail++;
            $display("FAIL read_req: got addr=%0d width=%0d, required addr=%0d width=%0d",
                     got.a, got.w, want.a, want.w);
          end
        end
        repeat (rd_lat) begin @(posedge clk); #1; end
        mem_rd_data  = mem.exists(int'(got.a)) ? mem[int'(got.a)] : 30'h0;
        mem_rd_valid = 1'b1;
        @(posedge clk); #1;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
      end
    end
  end

  // Output monitor: handshakes, backpressure hold, done/err/argmax.
  initial begin
    el_t  want_el, held;
    dn_t  want_dn;
    logic stall_prev;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && out_valid) begin
          nvec++;
          if ({out_data, out_last} != held || mem_rd_en) begin
            nfail++;
            $display("FAIL hold: got data=%h last=%0d rd_en=%0d, required data=%h last=%0d rd_en=0",
                     out_data, out_last, mem_rd_en, held.d, held.l);
          end
        end
        if (out_valid && out_ready) begin
          nvec++;
          if (exp_el_q.size() == 0) begin
            nfail++;
            $display("FAIL unexpected_output: got data=%h, required no output", out_data);
          end else begin
            want_el = exp_el_q.pop_front();
            if ({out_data, out_last} != want_el) begin
              nfail++;
              $display("FAIL element %0d: got data=%h last=%0d, required data=%h last=%0d",
                       hs_cnt, out_data, out_last, want_el.d, want_el.l);
            end else
              $display("elem %0d data=%h last=%0d ok", hs_cnt, out_data, out_last);
          end
          hs_cnt++;
          last_hs_cyc = cyc;
        end
        stall_prev = out_valid && !out_ready;
        held = '{d: out_data, l: out_last};
        if (done) begin
          nvec++;
          if (exp_dn_q.size() == 0) begin
            nfail++;
            $display("FAIL unexpected_done: got done=1, required no done");
          end else begin
            want_dn = exp_dn_q.pop_front();
            if (err != want_dn.e || argmax_idx != want_dn.idx ||
                (want_dn.chk_lat && cyc != last_hs_cyc + 1)) begin
              nfail++;
              $display("FAIL done: got err=%0d argmax=%0d lat=%0d, required err=%0d argmax=%0d lat=1",
                       err, argmax_idx, cyc - last_hs_cyc, want_dn.e, want_dn.idx);
            end else
              $display("done err=%0d argmax=%0d ok", err, argmax_idx);
          end
          done_cnt++;
        end
      end
    end
  end

  task automatic exp_rd(input logic [15:0] a, input logic w);
    exp_rd_q.push_back('{a: a, w: w});
  endtask

  task automatic exp_el(input logic [29:0] d, input logic l);
    exp_el_q.push_back('{d: d, l: l});
  endtask

  task automatic exp_dn(input logic e, input logic [6:0] idx, input logic chk);
    exp_dn_q.push_back('{e: e, idx: idx, chk_lat: chk});
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [6:0] n, input logic w);
    base_addr = b; num_elem = n; width = w; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int target;
    target = done_cnt + 1;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt >= target) begin
        tick(); tick();
        return;
      end
      tick();
    end
    nvec++; nfail++;
    $display("FAIL timeout %s: got no done, required done within 3000 cycles", name);
  endtask

  task automatic check_idle(input string name);
    nvec++;
    if ({mem_rd_en, mem_rd_addr, mem_rd_width, out_valid, out_data, out_last,
         busy, done, err, argmax_idx} != '0) begin
      nfail++;
      $display("FAIL %s: got en=%0d addr=%0d w=%0d ov=%0d data=%h last=%0d busy=%0d done=%0d err=%0d amax=%0d, required all 0",
               name, mem_rd_en, mem_rd_addr, mem_rd_width, out_valid, out_data, out_last,
               busy, done, err, argmax_idx);
    end else
      $display("%s outputs all zero ok", name);
  endtask

  initial begin
    int h0;
    rst = 1'b1; start = 1'b0; base_addr = '0; num_elem = '0; width = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check_idle("reset_state");
    rst = 1'b0;
    tick();

    // T1: single width at top of memory, sign extension, tie 2/4 keeps 2.
    mem[57334] = 30'h0000_0064; mem[57335] = 30'h2AAA_FFFD; mem[57336] = 30'h1555_3FFF;
    mem[57337] = 30'h0000_4000; mem[57338] = 30'h3FFF_BFFF;
    for (int i = 0; i < 5; i++) exp_rd(16'(57334 + i), 1'b0);
    exp_el(30'h0000_0064, 1'b0); exp_el(30'h3FFF_FFFD, 1'b0); exp_el(30'h0000_3FFF, 1'b0);
    exp_el(30'h3FFF_C000, 1'b0); exp_el(30'h0000_3FFF, 1'b1);
    exp_dn(1'b0, 7'd2, 1'b1);
    do_start(16'd57334, 7'd5, 1'b0);
    wait_done("single5");

    // T2: double width, stride 2, full 30-bit data.
    mem[0] = 30'h2000_0000; mem[2] = 30'h0000_0005; mem[4] = 30'h1FFF_FFFF; mem[6] = 30'h3FFF_FFFF;
    for (int i = 0; i < 4; i++) exp_rd(16'(2 * i), 1'b1);
    exp_el(30'h2000_0000, 1'b0); exp_el(30'h0000_0005, 1'b0);
    exp_el(30'h1FFF_FFFF, 1'b0); exp_el(30'h3FFF_FFFF, 1'b1);
    exp_dn(1'b0, 7'd2, 1'b1);
    do_start(16'd0, 7'd4, 1'b1);
    wait_done("double4");

    // T3: double width ending exactly at depth is legal.
    mem[57340] = 30'h0000_0007; mem[57342] = 30'h3FFF_FFF0;
    exp_rd(16'd57340, 1'b1); exp_rd(16'd57342, 1'b1);
    exp_el(30'h0000_0007, 1'b0); exp_el(30'h3FFF_FFF0, 1'b1);
    exp_dn(1'b0, 7'd0, 1'b1);
    do_start(16'd57340, 7'd2, 1'b1);
    wait_done("double_edge");

    // T4: backpressure on element 1 for 10 cycles.
    mem[100] = 30'h0000_0005; mem[101] = 30'h0000_0009; mem[102] = 30'h0000_0009;
    for (int i = 0; i < 3; i++) exp_rd(16'(100 + i), 1'b0);
    exp_el(30'h5, 1'b0); exp_el(30'h9, 1'b0); exp_el(30'h9, 1'b1);
    exp_dn(1'b0, 7'd1, 1'b1);
    h0 = hs_cnt;
    do_start(16'd100, 7'd3, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (out_valid && hs_cnt == h0 + 1) break;
      tick();
    end
    out_ready = 1'b0;
    repeat (10) tick();
    out_ready = 1'b1;
    wait_done("backpressure");

    // T5..T7: range errors and empty vector; no reads, argmax unchanged.
    exp_dn(1'b1, 7'd1, 1'b0);
    do_start(16'd57340, 7'd5, 1'b0);
    wait_done("range_end");
    exp_dn(1'b0, 7'd1, 1'b0);
    do_start(16'd500, 7'd0, 1'b0);
    wait_done("num_zero");
    exp_dn(1'b1, 7'd1, 1'b0);
    do_start(16'd0, 7'd65, 1'b0);
    wait_done("num_65");

    // T8: reset while waiting for read data; late data must be ignored.
    rd_lat = 6;
    mem[200] = 30'h0000_0123;
    exp_rd(16'd200, 1'b0);
    do_start(16'd200, 7'd2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (mem_rd_en) break;
      tick();
    end
    tick();
    rst = 1'b1;
    #1;
    check_idle("reset_in_wait");
    tick();
    rst = 1'b0;
    repeat (12) tick();
    check_idle("after_late_data");
    rd_lat = 2;

    // T9: normal transfer after the abort.
    mem[300] = 30'h0000_7FFB; mem[301] = 30'h0000_0003;
    exp_rd(16'd300, 1'b0); exp_rd(16'd301, 1'b0);
    exp_el(30'h3FFF_FFFB, 1'b0); exp_el(30'h0000_0003, 1'b1);
    exp_dn(1'b0, 7'd1, 1'b1);
    do_start(16'd300, 7'd2, 1'b0);
    wait_done("after_reset");

    repeat (5) tick();
    nvec++;
    if (exp_rd_q.size() != 0 || exp_el_q.size() != 0 || exp_dn_q.size() != 0) begin
      nfail++;
      $display("FAIL leftover: got rd=%0d el=%0d dn=%0d pending, required 0 0 0",
               exp_rd_q.size(), exp_el_q.size(), exp_dn_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before 2 ms");
    $fatal(1, "watchdog");
  end

endmodule
